mouse_axis_emu: RTL and testbench

- Parametrised mouse-to-analog-joystick emulator.
- Converts PS/2 mouse packets from hps_io into two saturated signed analog axes plus fire, and hands control back to the real joystick on joystick activity.
- Generalises the in-line mouse-as-joystick logic with:
  - configurable axis width and step clamp;
  - sensitivity scaling;
  - a self-centring "spring" mode with a programmable decay rate.
- Sits between hps_io and the core's joystick inputs.

---
 rtl/mouse_axis_emu.sv | 191 +++++++++++++++++++
 tb/tb_mouse_axis_emu.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_axis_emu.sv
// mouse_axis_emu
//   Emulates an analog joystick from PS/2 mouse packets delivered by hps_io.
//   Mouse deltas are sensitivity-scaled, clamped to +/-STEP_MAX and
//   accumulated into two saturated signed axes. In spring mode the axes
//   decay one LSB toward zero every (DECAY_BASE << decay_rate) cycles.
//   Any real joystick activity (or mode 0) hands the axes back to the
//   real joystick immediately.
//
// Ports
//   clk_sys     system clock, rising edge
//   reset       synchronous, active-high
//   ps2_mouse   hps_io mouse bus: [24] toggle strobe, [23:16] Y data,
//               [15:8] X data, [5]/[4] Y/X sign, [1:0] R/L buttons
//   joy_x/y     real joystick axes (signed)
//   joy_fire    real joystick fire
//   joy_active  real joystick activity, forces pass-through
//   mode        0 off, 1 absolute, 2 spring, 3 behaves as 1
//   sens        sensitivity shift (2 = unity)
//   decay_rate  spring period exponent
//   out_x/y     emulated or passed-through axes (signed, registered)
//   out_fire    emulated or passed-through fire (registered)
//   emu_active  high while the mouse owns the axes
module mouse_axis_emu #(
  parameter int W          = 8,
  parameter int STEP_MAX   = 10,
  parameter int DECAY_BASE = 4096,
  parameter bit INVERT_Y   = 1'b1
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic [24:0]         ps2_mouse,
  input  logic signed [W-1:0] joy_x,
  input  logic signed [W-1:0] joy_y,
  input  logic                joy_fire,
  input  logic                joy_active,
  input  logic [1:0]          mode,
  input  logic [1:0]          sens,
  input  logic [3:0]          decay_rate,
  output logic signed [W-1:0] out_x,
  output logic signed [W-1:0] out_y,
  output logic                out_fire,
  output logic                emu_active
);

  typedef enum logic {PASS, EMU} state_t;

  // Counter sized so the terminal count still fits at decay_rate = 15.
  localparam int CW = $clog2(DECAY_BASE) + 16;

  localparam logic signed [11:0]  STEP_HI = 12'(STEP_MAX);
  localparam logic signed [11:0]  STEP_LO = -STEP_HI;
  localparam logic signed [W+1:0] ACC_HI  = (W+2)'((1 <<< (W-1)) - 1);
  localparam logic signed [W+1:0] ACC_LO  = -ACC_HI - (W+2)'(1);

  // Sign-extend the 9-bit delta, scale by 2^sens / 4 with arithmetic
  // shifts (so negative deltas round toward -inf), then clamp.
  function automatic logic signed [11:0] scale_step(input logic [8:0] d,
                                                    input logic [1:0] sh);
    logic signed [11:0] v;
    v = {{3{d[8]}}, d};
    v = (v <<< sh) >>> 2;
    if (v > STEP_HI)
      v = STEP_HI;
    else if (v < STEP_LO)
      v = STEP_LO;
    return v;
  endfunction

  // Add or subtract a step in W+2 bits and saturate back to W bits.
  function automatic logic signed [W-1:0] sat_acc(input logic signed [W-1:0] a,
                                                  input logic signed [11:0]  st,
                                                  input logic                sub);
    logic signed [W+1:0] ae;
    logic signed [W+1:0] se;
    logic signed [W+1:0] sum;
    ae  = (W+2)'(a);
    se  = (W+2)'(st);
    sum = sub ? (ae - se) : (ae + se);
    if (sum > ACC_HI)
      sum = ACC_HI;
    else if (sum < ACC_LO)
      sum = ACC_LO;
    return W'(sum);
  endfunction

  function automatic logic signed [W-1:0] toward_zero(input logic signed [W-1:0] a);
    logic signed [W-1:0] r;
    if (a == '0)
      r = a;
    else if (a[W-1])
      r = a + W'(1);
    else
      r = a - W'(1);
    return r;
  endfunction

  state_t              state;
  state_t              state_n;
  logic signed [W-1:0] acc_x;
  logic signed [W-1:0] acc_y;
  logic signed [W-1:0] acc_x_n;
  logic signed [W-1:0] acc_y_n;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_n;
  logic [CW-1:0]       term;
  logic                old_stb;
  logic                pkt;
  logic                spring;
  logic                tick;
  logic [8:0]          dx;
  logic [8:0]          dy;
  logic signed [11:0]  step_x;
  logic signed [11:0]  step_y;
  logic                unused_bits;

  assign unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3:2]};

  assign pkt        = ps2_mouse[24] ^ old_stb;
  assign dx         = {ps2_mouse[4], ps2_mouse[15:8]};
  assign dy         = {ps2_mouse[5], ps2_mouse[23:16]};
  assign step_x     = scale_step(dx, sens);
  assign step_y     = scale_step(dy, sens);
  assign spring     = (mode == 2'd2);
  assign term       = (CW'(DECAY_BASE) << decay_rate) - CW'(1);
  assign emu_active = (state == EMU);

  always_comb begin
    state_n = state;
    acc_x_n = acc_x;
    acc_y_n = acc_y;
    cnt_n   = cnt;
    tick    = 1'b0;
    case (state)
      PASS: begin
        acc_x_n = '0;
        acc_y_n = '0;
        cnt_n   = '0;
        if (pkt && (mode != 2'd0) && !joy_active) begin
          state_n = EMU;
          acc_x_n = sat_acc('0, step_x, 1'b0);
          acc_y_n = sat_acc('0, step_y, INVERT_Y);
        end
      end
      EMU: begin
        if (joy_active || (mode == 2'd0)) begin
          state_n = PASS;
          acc_x_n = '0;
          acc_y_n = '0;
          cnt_n   = '0;
        end else begin
          tick  = spring && (cnt == term);
          cnt_n = (spring && !tick) ? cnt + CW'(1) : '0;
          // A packet on a tick cycle takes the update; the tick is lost.
          if (pkt) begin
            acc_x_n = sat_acc(acc_x, step_x, 1'b0);
            acc_y_n = sat_acc(acc_y, step_y, INVERT_Y);
          end else if (tick) begin
            acc_x_n = toward_zero(acc_x);
            acc_y_n = toward_zero(acc_y);
          end
        end
      end
      default: state_n = PASS;
    endcase
  end

  // Outputs are driven from the already-registered state/acc, so they
  // appear one edge after the update that produced them.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= PASS;
      acc_x    <= '0;
      acc_y    <= '0;
      cnt      <= '0;
      old_stb  <= ps2_mouse[24];
      out_x    <= '0;
      out_y    <= '0;
      out_fire <= 1'b0;
    end else begin
      state    <= state_n;
      acc_x    <= acc_x_n;
      acc_y    <= acc_y_n;
      cnt      <= cnt_n;
      old_stb  <= ps2_mouse[24];
      out_x    <= emu_active ? acc_x : joy_x;
      out_y    <= emu_active ? acc_y : joy_y;
      out_fire <= emu_active ? |ps2_mouse[1:0] : joy_fire;
    end
  end

endmodule

// File: tb/tb_mouse_axis_emu.sv
// tb_mouse_axis_emu
//   Directed bench for mouse_axis_emu (W=8, STEP_MAX=10, DECAY_BASE=4,
//   INVERT_Y=1). A vector table covers scaling/clamping/accumulation;
//   hand sequences cover saturation, spring decay timing, takeover,
//   reset behaviour and mode 0/3.
module tb_mouse_axis_emu;

  logic              clk = 1'b0;
  logic              reset;
  logic [24:0]       ps2;
  logic signed [7:0] joy_x;
  logic signed [7:0] joy_y;
  logic              joy_fire;
  logic              joy_active;
  logic [1:0]        mode;
  logic [1:0]        sens;
  logic [3:0]        decay_rate;
  logic signed [7:0] out_x;
  logic signed [7:0] out_y;
  logic              out_fire;
  logic              emu_active;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mouse_axis_emu #(
    .W(8),
    .STEP_MAX(10),
    .DECAY_BASE(4),
    .INVERT_Y(1'b1)
  ) dut (
    .clk_sys(clk),
    .reset(reset),
    .ps2_mouse(ps2),
    .joy_x(joy_x),
    .joy_y(joy_y),
    .joy_fire(joy_fire),
    .joy_active(joy_active),
    .mode(mode),
    .sens(sens),
    .decay_rate(decay_rate),
    .out_x(out_x),
    .out_y(out_y),
    .out_fire(out_fire),
    .emu_active(emu_active)
  );

  typedef struct {
    logic [1:0] sens;
    int         dx;
    int         dy;
    logic [1:0] btn;
    int         ex;
    int         ey;
    logic       efire;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a packet (toggle strobe) without advancing the clock.
  task automatic load(input int dx, input int dy, input logic [1:0] btn);
    logic [8:0] x9;
    logic [8:0] y9;
    x9 = 9'(dx);
    y9 = 9'(dy);
    ps2[15:8]  = x9[7:0];
    ps2[4]     = x9[8];
    ps2[23:16] = y9[7:0];
    ps2[5]     = y9[8];
    ps2[1:0]   = btn;
    ps2[24]    = ~ps2[24];
  endtask

  task automatic pkt(input int dx, input int dy, input logic [1:0] btn);
    load(dx, dy, btn);
    step();
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int ex, input int ey,
                         input int eemu, input int efire);
    check({tag, ".x"}, out_x, ex);
    check({tag, ".y"}, out_y, ey);
    check({tag, ".emu"}, int'(emu_active), eemu);
    check({tag, ".fire"}, int'(out_fire), efire);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    // Cumulative expectations, mode 1, starting from acc = 0.
    vecs[0] = '{2'd2,    5,    3, 2'b01,   5, -3, 1'b1};
    vecs[1] = '{2'd2,   -2,   -4, 2'b00,   3,  1, 1'b0};
    vecs[2] = '{2'd2,  200,    0, 2'b00,  13,  1, 1'b0};
    vecs[3] = '{2'd1,    8,   -8, 2'b10,  17,  5, 1'b1};
    vecs[4] = '{2'd0,    7,    0, 2'b00,  18,  5, 1'b0};
    vecs[5] = '{2'd0,   -7,    0, 2'b00,  16,  5, 1'b0};
    vecs[6] = '{2'd3,    2,    3, 2'b11,  20, -1, 1'b1};
    vecs[7] = '{2'd3, -200, -200, 2'b00,  10,  9, 1'b0};

    reset      = 1'b1;
    ps2        = '0;
    joy_x      = 8'sd25;
    joy_y      = -8'sd6;
    joy_fire   = 1'b1;
    joy_active = 1'b0;
    mode       = 2'd1;
    sens       = 2'd2;
    decay_rate = 4'd0;
    step();
    step();
    chk_all("reset", 0, 0, 0, 0);
    reset = 1'b0;
    step();
    chk_all("pass_idle", 25, -6, 0, 1);
    joy_x    = '0;
    joy_y    = '0;
    joy_fire = 1'b0;
    step();

    // Table: packet, one idle edge, then outputs reflect the new acc.
    for (int unsigned i = 0; i < 8; i++) begin
      sens = vecs[i].sens;
      pkt(vecs[i].dx, vecs[i].dy, vecs[i].btn);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, 1, int'(vecs[i].efire));
    end

    // Saturation at both rails.
    do_reset();
    mode = 2'd1;
    sens = 2'd2;
    repeat (14) pkt(200, 0, 0);
    step();
    check("sat_pos14.x", out_x, 127);
    pkt(200, 0, 0);
    step();
    check("sat_pos15.x", out_x, 127);
    check("sat_pos15.y", out_y, 0);
    repeat (30) pkt(-200, -200, 0);
    step();
    check("sat_neg.x", out_x, -128);
    check("sat_neg.y", out_y, 127);

    // Quarter sensitivity with arithmetic shift.
    do_reset();
    sens = 2'd0;
    pkt(7, 0, 0);
    step();
    check("sens0_pos.x", out_x, 1);
    pkt(-7, 0, 0);
    step();
    check("sens0_neg.x", out_x, -1);

    // Spring decay: period 8 with DECAY_BASE=4, decay_rate=1.
    do_reset();
    sens       = 2'd2;
    decay_rate = 4'd1;
    pkt(3, 0, 0);
    mode = 2'd2;
    for (int unsigned k = 1; k <= 25; k++) begin
      step();
      check($sformatf("decay_k%0d.x", k), out_x,
            (k < 9) ? 3 : (k < 17) ? 2 : (k < 25) ? 1 : 0);
    end
    check("decay.emu", int'(emu_active), 1);
    pkt(5, 0, 0);
    repeat (5) step();
    pkt(1, 0, 0);          // lands on the tick edge
    step();
    check("tick_pkt.x", out_x, 6);
    repeat (7) step();
    check("tick_restart.x", out_x, 6);
    step();
    check("tick_next.x", out_x, 5);
    check("tick_next.y", out_y, 0);

    // Joystick takeover beats a simultaneous packet.
    do_reset();
    mode = 2'd1;
    sens = 2'd2;
    repeat (4) pkt(10, 0, 0);
    step();
    check("pre_take.x", out_x, 40);
    joy_active = 1'b1;
    joy_x      = -8'sd17;
    joy_y      = 8'sd9;
    joy_fire   = 1'b1;
    load(10, 0, 2'b01);
    step();
    check("take_edge.emu", int'(emu_active), 0);
    check("take_edge.x", out_x, 40);
    step();
    chk_all("take", -17, 9, 0, 1);
    joy_active = 1'b0;
    step();
    check("take_hold.x", out_x, -17);
    check("take_hold.emu", int'(emu_active), 0);
    pkt(2, 0, 0);
    step();
    chk_all("reentry", 2, 0, 1, 0);

    // Strobe toggled during reset is not a packet after release.
    joy_x    = '0;
    joy_y    = '0;
    joy_fire = 1'b0;
    reset    = 1'b1;
    step();
    ps2[24] = ~ps2[24];
    step();
    reset = 1'b0;
    step();
    step();
    check("rst_tog.emu", int'(emu_active), 0);
    check("rst_tog.x", out_x, 0);

    // Mode 0 ignores packets and tracks the joystick.
    joy_x = 8'sd33;
    joy_y = -8'sd5;
    mode  = 2'd0;
    repeat (3) pkt(5, 5, 2'b11);
    step();
    chk_all("mode0", 33, -5, 0, 0);

    // Reset mid-operation with a coincident packet.
    mode = 2'd1;
    pkt(10, 10, 0);
    pkt(10, 10, 0);
    step();
    check("pre_mid.x", out_x, 20);
    reset = 1'b1;
    load(10, 0, 0);
    step();
    chk_all("midreset", 0, 0, 0, 0);
    reset = 1'b0;
    step();

    // Mode 3 behaves as absolute: no decay.
    joy_x      = '0;
    joy_y      = '0;
    mode       = 2'd3;
    decay_rate = 4'd0;
    pkt(4, 0, 0);
    repeat (20) step();
    check("mode3.x", out_x, 4);
    check("mode3.emu", int'(emu_active), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
